// File: rtl/line_fetch_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : line_fetch_scheduler_if
// Description : Burst-read request channel between the line fetch scheduler
//               and the frame-buffer memory reader.
//               master (scheduler): rd_req, rd_addr, rd_len, rd_bank out;
//                                   rd_ack, rd_done in
//               slave  (reader)   : the mirror image
//               rd_req  - request, held until rd_ack
//               rd_addr - burst start byte address, stable while rd_req=1
//               rd_len  - burst length in bytes
//               rd_bank - destination line-buffer bank
//               rd_ack  - reader accepted the request
//               rd_done - one-cycle pulse, burst written into rd_bank
// Revision    : 1.0 - initial release
// ============================================================================
interface line_fetch_scheduler_if #(
    parameter int ADDR_W = 32
) ();
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       rd_len;
    logic              rd_bank;
    logic              rd_ack;
    logic              rd_done;

    modport master (
        output rd_req,
        output rd_addr,
        output rd_len,
        output rd_bank,
        input  rd_ack,
        input  rd_done
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        input  rd_len,
        input  rd_bank,
        output rd_ack,
        output rd_done
    );
endinterface
`default_nettype wire

// File: rtl/line_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : line_fetch_scheduler
// Description : Sequences frame-buffer line reads for the video output path.
//               A rising edge of prefetch_line arms a frame; one burst read
//               per active line is issued into a two-bank line buffer and the
//               display-side bank pointer is tracked against linestart.
// Ports       : video_clk     - pixel clock, rising edge
//               reset_n       - asynchronous active-low reset
//               enable        - allows arming of a new frame
//               frame_base    - byte address of line 0 (sampled at arm)
//               line_stride   - byte pitch between lines (sampled at arm)
//               framestart    - start-of-frame pulse
//               prefetch_line - level; rising edge arms a frame fetch
//               linestart     - pulse before each active line
//               clear_err     - clears underflow / overrun
//               disp_bank     - bank the display reads this line
//               bank_valid    - per-bank line-ready flags
//               underflow     - sticky: line not ready at linestart
//               overrun       - sticky: arm while busy / framestart in WAIT
//               busy          - FSM not idle
//               rd            - read request channel (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module line_fetch_scheduler #(
    parameter int ADDR_W     = 32,
    parameter int V_ACTIVE   = 900,
    parameter int LINE_BYTES = 6400
) (
    input  wire logic              video_clk,
    input  wire logic              reset_n,
    input  wire logic              enable,
    input  wire logic [ADDR_W-1:0] frame_base,
    input  wire logic [15:0]       line_stride,
    input  wire logic              framestart,
    input  wire logic              prefetch_line,
    input  wire logic              linestart,
    input  wire logic              clear_err,
    output logic                   disp_bank,
    output logic [1:0]             bank_valid,
    output logic                   underflow,
    output logic                   overrun,
    output logic                   busy,
    line_fetch_scheduler_if.master rd
);

    localparam int                 c_cnt_w    = $clog2(V_ACTIVE + 1);
    localparam logic [c_cnt_w-1:0] c_last     = c_cnt_w'(V_ACTIVE);
    localparam logic [15:0]        c_line_len = 16'(LINE_BYTES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_REQ   = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic                r_prefetch_d;
    logic [c_cnt_w-1:0]  r_fetch_cnt;
    logic [ADDR_W-1:0]   r_addr_acc;
    logic [15:0]         r_stride;
    logic                r_wr_bank;
    logic                r_showing;
    logic                r_discard;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_rd_bank;
    logic [1:0]          r_bank_valid;
    logic                r_disp_bank;
    logic                r_underflow;
    logic                r_overrun;

    logic                w_arm;
    logic                w_arm_overrun;
    logic                w_issue;
    logic                w_done_set;
    logic                w_set_discard;
    logic                w_clr_discard;
    logic                w_fs_overrun;
    logic                w_show_bank;
    logic                w_show_ok;
    logic [1:0]          w_bank_valid_nxt;
    logic                w_underflow_evt;

    assign w_arm         = prefetch_line & ~r_prefetch_d & enable;
    assign w_arm_overrun = w_arm & (r_state != S_IDLE);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge video_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state  = r_state;
        w_issue       = 1'b0;
        w_done_set    = 1'b0;
        w_set_discard = 1'b0;
        w_clr_discard = 1'b0;
        w_fs_overrun  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_arm) begin
                    w_next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                if (framestart || (r_fetch_cnt == c_last)) begin
                    w_next_state = S_IDLE;
                end else if (!r_bank_valid[r_wr_bank]) begin
                    w_next_state = S_REQ;
                    w_issue      = 1'b1;
                end
            end
            S_REQ: begin
                if (framestart) begin
                    w_next_state = S_IDLE;
                end else if (rd.rd_ack) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (framestart) begin
                    // The burst in flight belongs to the old frame. If it
                    // completes in this very cycle there is nothing left to
                    // discard; otherwise swallow the coming rd_done.
                    w_fs_overrun = 1'b1;
                    if (rd.rd_done) begin
                        w_next_state  = S_IDLE;
                        w_clr_discard = 1'b1;
                    end else begin
                        w_set_discard = 1'b1;
                    end
                end else if (rd.rd_done) begin
                    if (r_discard) begin
                        w_clr_discard = 1'b1;
                        w_next_state  = S_IDLE;
                    end else begin
                        w_done_set    = 1'b1;
                        w_next_state  = S_CHECK;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Display side: bank to be checked at linestart and bank-valid update.
    // A burst completing into the checked bank in the same cycle counts as
    // ready (bypass), so it does not raise underflow.
    // ------------------------------------------------------------------
    always_comb begin
        w_show_bank      = r_showing ? ~r_disp_bank : r_disp_bank;
        w_show_ok        = r_bank_valid[w_show_bank] |
                           (w_done_set & (r_wr_bank == w_show_bank));
        w_bank_valid_nxt = r_bank_valid;
        if (linestart && r_showing) begin
            w_bank_valid_nxt[r_disp_bank] = 1'b0;
        end
        if (w_done_set) begin
            w_bank_valid_nxt[r_wr_bank] = 1'b1;
        end
        w_underflow_evt  = linestart & ~framestart & ~w_show_ok;
    end

    // ------------------------------------------------------------------
    // Datapath and bookkeeping registers
    // ------------------------------------------------------------------
    always_ff @(posedge video_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prefetch_d <= 1'b0;
            r_fetch_cnt  <= '0;
            r_addr_acc   <= '0;
            r_stride     <= '0;
            r_wr_bank    <= 1'b0;
            r_showing    <= 1'b0;
            r_discard    <= 1'b0;
            r_rd_addr    <= '0;
            r_rd_bank    <= 1'b0;
            r_bank_valid <= 2'b00;
            r_disp_bank  <= 1'b0;
            r_underflow  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_prefetch_d <= prefetch_line;

            if (w_issue) begin
                r_rd_addr <= r_addr_acc;
                r_rd_bank <= r_wr_bank;
            end

            if ((r_state == S_IDLE) && w_arm) begin
                r_addr_acc  <= frame_base;
                r_stride    <= line_stride;
                r_fetch_cnt <= '0;
            end else if (w_done_set) begin
                r_addr_acc  <= r_addr_acc + ADDR_W'(r_stride);
                r_fetch_cnt <= r_fetch_cnt + 1'b1;
            end

            if (w_set_discard) begin
                r_discard <= 1'b1;
            end else if (w_clr_discard) begin
                r_discard <= 1'b0;
            end

            if (framestart) begin
                r_bank_valid <= 2'b00;
                r_disp_bank  <= 1'b0;
                r_wr_bank    <= 1'b0;
                r_showing    <= 1'b0;
            end else begin
                r_bank_valid <= w_bank_valid_nxt;
                if (w_done_set) begin
                    r_wr_bank <= ~r_wr_bank;
                end
                if (linestart) begin
                    // On a miss the pointer parks on the missing bank so the
                    // next linestart re-checks that same bank.
                    r_disp_bank <= w_show_bank;
                    r_showing   <= w_show_ok;
                end
            end

            r_underflow <= (r_underflow & ~clear_err) | w_underflow_evt;
            r_overrun   <= (r_overrun & ~clear_err) | w_fs_overrun | w_arm_overrun;
        end
    end

    assign rd.rd_req   = (r_state == S_REQ);
    assign rd.rd_addr  = r_rd_addr;
    assign rd.rd_len   = c_line_len;
    assign rd.rd_bank  = r_rd_bank;
    assign disp_bank   = r_disp_bank;
    assign bank_valid  = r_bank_valid;
    assign underflow   = r_underflow;
    assign overrun     = r_overrun;
    assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_line_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_fetch_scheduler
// Description : Self-checking bench for line_fetch_scheduler. A cycle table
//               of directed vectors covers arming, underflow, bypass, arm
//               overrun and framestart abort; hand-written sequences cover a
//               full (shortened) frame, back-pressure, bank-full stall,
//               framestart during WAIT and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_fetch_scheduler;

    localparam int          ADDR_W  = 32;
    localparam int          V_ACT   = 6;
    localparam int          LINE_B  = 6400;
    localparam logic [31:0] BASE_A  = 32'h1000_0000;
    localparam logic [31:0] BASE_B  = 32'h2000_0000;
    localparam logic [31:0] STRIDE  = 32'd6400;

    logic              video_clk = 1'b0;
    logic              reset_n   = 1'b0;
    logic              enable;
    logic [ADDR_W-1:0] frame_base;
    logic [15:0]       line_stride;
    logic              framestart;
    logic              prefetch_line;
    logic              linestart;
    logic              clear_err;
    logic              disp_bank;
    logic [1:0]        bank_valid;
    logic              underflow;
    logic              overrun;
    logic              busy;

    line_fetch_scheduler_if #(.ADDR_W(ADDR_W)) rd_bus ();

    line_fetch_scheduler #(
        .ADDR_W     (ADDR_W),
        .V_ACTIVE   (V_ACT),
        .LINE_BYTES (LINE_B)
    ) dut (
        .video_clk     (video_clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .frame_base    (frame_base),
        .line_stride   (line_stride),
        .framestart    (framestart),
        .prefetch_line (prefetch_line),
        .linestart     (linestart),
        .clear_err     (clear_err),
        .disp_bank     (disp_bank),
        .bank_valid    (bank_valid),
        .underflow     (underflow),
        .overrun       (overrun),
        .busy          (busy),
        .rd            (rd_bus)
    );

    always #5 video_clk = ~video_clk;

    int checks = 0;
    int errors = 0;

    // {fs, pf, ls, ack, done, clr} applied for one edge, then expected
    // {rd_req, rd_bank, bank_valid[1:0], disp_bank, underflow, overrun, busy}
    typedef struct packed {
        logic       fs;
        logic       pf;
        logic       ls;
        logic       ack;
        logic       done;
        logic       clr;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {rd_bus.rd_req, rd_bus.rd_bank, bank_valid, disp_bank, underflow, overrun, busy};
    endfunction

    task automatic tick();
        @(posedge video_clk);
        #1;
    endtask

    task automatic clear_inputs();
        framestart     = 1'b0;
        prefetch_line  = 1'b0;
        linestart      = 1'b0;
        clear_err      = 1'b0;
        rd_bus.rd_ack  = 1'b0;
        rd_bus.rd_done = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        enable      = 1'b1;
        frame_base  = BASE_A;
        line_stride = STRIDE[15:0];
        reset_n     = 1'b0;
        tick();
        tick();
        reset_n     = 1'b1;
        tick();
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rd_bus.rd_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic pulse_ack();
        rd_bus.rd_ack = 1'b1;
        tick();
        rd_bus.rd_ack = 1'b0;
    endtask

    task automatic pulse_done();
        rd_bus.rd_done = 1'b1;
        tick();
        rd_bus.rd_done = 1'b0;
    endtask

    task automatic pulse_ls();
        linestart = 1'b1;
        tick();
        linestart = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        bit          flag;
        logic [31:0] a0;
        logic        b0;

        //            fs pf ls ak dn cl  rq bk bv   dp uf ov by
        vecs[0]  = '{0, 1, 0, 0, 0, 0, 8'b0_0_00_0_0_0_1};
        vecs[1]  = '{0, 1, 0, 0, 0, 0, 8'b1_0_00_0_0_0_1};
        vecs[2]  = '{0, 1, 0, 0, 0, 0, 8'b1_0_00_0_0_0_1};
        vecs[3]  = '{0, 1, 0, 1, 0, 0, 8'b0_0_00_0_0_0_1};
        vecs[4]  = '{0, 1, 1, 0, 0, 0, 8'b0_0_00_0_1_0_1};
        vecs[5]  = '{0, 1, 0, 0, 1, 0, 8'b0_0_01_0_1_0_1};
        vecs[6]  = '{0, 1, 0, 0, 0, 1, 8'b1_1_01_0_0_0_1};
        vecs[7]  = '{0, 1, 1, 1, 0, 0, 8'b0_1_01_0_0_0_1};
        vecs[8]  = '{0, 1, 1, 0, 1, 0, 8'b0_1_10_1_0_0_1};
        vecs[9]  = '{0, 1, 0, 0, 0, 0, 8'b1_0_10_1_0_0_1};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 8'b1_0_10_1_0_0_1};
        vecs[11] = '{0, 1, 0, 0, 0, 0, 8'b1_0_10_1_0_1_1};
        vecs[12] = '{0, 1, 0, 0, 0, 1, 8'b1_0_10_1_0_0_1};
        vecs[13] = '{1, 1, 0, 0, 0, 0, 8'b0_0_00_0_0_0_0};
        vecs[14] = '{0, 0, 1, 0, 0, 0, 8'b0_0_00_0_1_0_0};
        vecs[15] = '{0, 1, 1, 0, 0, 1, 8'b0_0_00_0_1_0_1};
        vecs[16] = '{0, 1, 0, 0, 0, 0, 8'b1_0_00_0_1_0_1};

        // ---------------- reset state ----------------
        do_reset();
        check("reset_outs", outs(), 8'h00);
        check("reset_rd_len", rd_bus.rd_len, 16'd6400);

        // ---------------- table vectors ----------------
        for (int i = 0; i < 17; i++) begin
            framestart     = vecs[i].fs;
            prefetch_line  = vecs[i].pf;
            linestart      = vecs[i].ls;
            rd_bus.rd_ack  = vecs[i].ack;
            rd_bus.rd_done = vecs[i].done;
            clear_err      = vecs[i].clr;
            tick();
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end
        check("vec16_addr", rd_bus.rd_addr, BASE_A);
        clear_inputs();

        // ---------------- normal frame ----------------
        do_reset();
        prefetch_line = 1'b1;
        tick();
        for (int n = 0; n < V_ACT; n++) begin
            wait_req(ok);
            check($sformatf("frame_req%0d_seen", n), ok, 1'b1);
            check($sformatf("frame_req%0d_addr_bank", n),
                  {rd_bus.rd_addr, rd_bus.rd_bank},
                  {BASE_A + 32'(n) * STRIDE, 1'(n % 2)});
            pulse_ack();
            repeat (20) tick();
            pulse_done();
            repeat (5) tick();
            pulse_ls();
        end
        check("frame_end", {busy, underflow, overrun, rd_bus.rd_req}, 4'b0000);
        repeat (10) tick();
        check("frame_no_extra_req", {busy, rd_bus.rd_req}, 2'b00);

        // ---------------- back-pressure ----------------
        do_reset();
        prefetch_line = 1'b1;
        tick();
        wait_req(ok);
        check("bp_req_seen", ok, 1'b1);
        a0 = rd_bus.rd_addr;
        b0 = rd_bus.rd_bank;
        check("bp_first", {a0, b0}, {BASE_A, 1'b0});
        flag = 1'b1;
        repeat (50) begin
            tick();
            if ({rd_bus.rd_req, rd_bus.rd_addr, rd_bus.rd_bank} !== {1'b1, a0, b0}) flag = 1'b0;
        end
        check("bp_stable", flag, 1'b1);
        pulse_ack();
        flag = 1'b1;
        repeat (4) begin
            if (rd_bus.rd_req !== 1'b0 || busy !== 1'b1) flag = 1'b0;
            tick();
        end
        check("bp_single_accept", flag, 1'b1);
        pulse_done();
        check("bp_done_bv", bank_valid, 2'b01);

        // ---------------- bank full ----------------
        wait_req(ok);
        check("full_req1_addr_bank", {ok, rd_bus.rd_addr, rd_bus.rd_bank}, {1'b1, BASE_A + STRIDE, 1'b1});
        pulse_ack();
        pulse_done();
        repeat (10) tick();
        check("full_hold", {rd_bus.rd_req, bank_valid, busy}, 4'b0111);
        pulse_ls();
        check("full_ls_first", {rd_bus.rd_req, bank_valid, disp_bank}, 4'b0110);
        pulse_ls();
        check("full_ls_free", {rd_bus.rd_req, bank_valid, disp_bank}, 4'b0101);
        ok = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (rd_bus.rd_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("full_next_req", {ok, rd_bus.rd_addr, rd_bus.rd_bank}, {1'b1, BASE_A + 2 * STRIDE, 1'b0});

        // ---------------- framestart during WAIT ----------------
        pulse_ack();
        framestart = 1'b1;
        tick();
        framestart = 1'b0;
        check("fs_wait", {overrun, bank_valid, disp_bank, busy, rd_bus.rd_req}, 6'b1_00_0_1_0);
        pulse_done();
        check("fs_discard", {bank_valid, busy, rd_bus.rd_req, overrun}, 5'b00_0_0_1);
        frame_base    = BASE_B;
        prefetch_line = 1'b0;
        tick();
        prefetch_line = 1'b1;
        tick();
        wait_req(ok);
        check("rearm", {ok, rd_bus.rd_addr, rd_bus.rd_bank}, {1'b1, BASE_B, 1'b0});

        // ---------------- async reset mid-REQ ----------------
        #3;
        prefetch_line = 1'b0;
        reset_n       = 1'b0;
        #1;
        check("async_rst", {rd_bus.rd_req, busy, bank_valid, overrun}, 5'b0);
        @(posedge video_clk);
        #1;
        reset_n = 1'b1;
        pulse_done();
        check("late_done", {busy, bank_valid, rd_bus.rd_req}, 4'b0);

        // ---------------- enable gating ----------------
        enable = 1'b0;
        tick();
        prefetch_line = 1'b1;
        tick();
        tick();
        check("enable_gate", {busy, rd_bus.rd_req, overrun}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
